// File: rtl/sync_fifo_reader_pkg.sv
// sync_fifo_reader_pkg
// Shared types and constants for the FIFO drain adapter.
//   occ_state_e : occupancy state of the 2-entry output buffer.
//                 The encoding equals the number of words held.
//   SKID_DEPTH  : number of words the output buffer can hold.
//   occ_count() : word count for a given occupancy state.
package sync_fifo_reader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  localparam logic [2:0] SKID_DEPTH = 3'd2;

  function automatic logic [1:0] occ_count(input occ_state_e s);
    logic [1:0] n;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// sync_fifo_reader_if
// Bundles the FIFO read port and the downstream stream of the drain adapter.
//   fifo_empty   : FIFO empty flag (from FIFO)
//   fifo_rd_en   : FIFO read strobe (to FIFO); data returns one cycle later
//   fifo_rd_data : FIFO read data (from FIFO)
//   m_valid      : stream word valid (to consumer)
//   m_ready      : consumer accept (from consumer)
//   m_data       : stream word (to consumer)
// Stream handshake: a word transfers on every rising clk edge where
// m_valid && m_ready. Once m_valid is high it stays high and m_data stays
// unchanged until that transfer happens; m_valid never depends on m_ready.
// Modports: master = the reader block, slave = FIFO plus consumer side.
interface sync_fifo_reader_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/sync_fifo_reader_skid.sv
// sync_fifo_reader_skid
// Two-entry output buffer with occupancy FSM (EMPTY/ONE/TWO).
// The main register always drives the stream; the skid register holds a
// second word that arrived while the main word was stalled.
//   clk, rst_n   : clock, asynchronous active-low reset
//   capture_i    : cap_data_i holds a word that must be stored this cycle
//   cap_data_i   : word to store
//   ready_i      : consumer accept
//   valid_o      : stream valid (registered)
//   data_o       : stream data (registered)
//   state_o      : current occupancy state (also used for debug)
module sync_fifo_reader_skid
  import sync_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output occ_state_e            state_o
);

  occ_state_e            state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;

  assign pop = valid_q && ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (capture_i) begin
          state_d = ONE;
          main_d  = cap_data_i;
        end
      end
      ONE: begin
        if (capture_i && !pop) begin
          state_d = TWO;
          skid_d  = cap_data_i;
        end else if (capture_i && pop) begin
          main_d = cap_data_i;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // The upstream credit check keeps capture_i low here.
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Separate flop so m_valid comes straight from a register, not a decode.
    valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = main_q;
  assign state_o = state_q;

`ifndef SYNTHESIS
  a_no_capture_in_two: assert property (
    @(posedge clk) disable iff (!rst_n) !(state_q == TWO && capture_i)
  ) else $error("sync_fifo_reader_skid: word captured while buffer full");
`endif

endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader
// Drain-side adapter for the synchronous FIFO: issues FIFO reads against a
// 2-word credit, captures the read data one cycle later and presents it as a
// valid/ready stream. Sustains 1 word/cycle under continuous m_ready.
// Optional macro SYNC_FIFO_READER_STATS_EN adds the saturating beat_cnt port.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : when low no new FIFO reads start; buffered words still drain
//   bus        : FIFO read port + output stream (master modport)
//   busy       : buffer not empty or a read in flight
//   beat_cnt   : saturating count of stream transfers (stats build only)
module sync_fifo_reader
  import sync_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  sync_fifo_reader_if.master   bus,
  output logic                 busy
`ifdef SYNC_FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] beat_cnt
`endif
);

  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("sync_fifo_reader: CNT_WIDTH must be at least 1");
  end

  occ_state_e occ_state;
  logic       inflight_q, inflight_d;
  logic       pop;
  logic       rd_en;
  logic [2:0] credit_sum;

  assign pop = bus.m_valid && bus.m_ready;

  // Words held + word in flight - word leaving this cycle must leave room
  // for the read being issued now. pop only occurs with occupancy >= 1, so
  // the sum cannot underflow. rst_n gates the strobe so nothing is read
  // from the FIFO while reset is held.
  always_comb begin
    credit_sum = {1'b0, occ_count(occ_state)} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = rst_n && enable && !bus.fifo_empty && (credit_sum < SKID_DEPTH);
    inflight_d = rd_en;
  end

  assign bus.fifo_rd_en = rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  sync_fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture_i  (inflight_q),
    .cap_data_i (bus.fifo_rd_data),
    .ready_i    (bus.m_ready),
    .valid_o    (bus.m_valid),
    .data_o     (bus.m_data),
    .state_o    (occ_state)
  );

  assign busy = (occ_state != EMPTY) || inflight_q;

`ifdef SYNC_FIFO_READER_STATS_EN
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop && (beat_cnt_q != {CNT_WIDTH{1'b1}})) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader
// Bench for sync_fifo_reader: behavioural FIFO model with 1-cycle read
// latency, per-cycle vector tables for streaming and backpressure, hand
// sequences for reset, empty guard, enable drop and the stats counter, and
// an ordering scoreboard fed by every word pushed into the FIFO model.
module tb_sync_fifo_reader;

  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic busy;
`ifdef SYNC_FIFO_READER_STATS_EN
  logic [CW-1:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  sync_fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy)
`ifdef SYNC_FIFO_READER_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem [DEPTH];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            rd_when_empty = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (rd_ptr == wr_ptr) begin
        rd_when_empty <= rd_when_empty + 1;
      end else begin
        bus.fifo_rd_data <= mem[rd_ptr % DEPTH];
        rd_ptr           <= rd_ptr + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Drops whatever is still queued in the FIFO model and the scoreboard.
  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  task automatic sb_check();
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra_word: got %h expected no word", bus.m_data);
      end else begin
        chk("sb_order", bus.m_data, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic at_neg();
    @(negedge clk);
    sb_check();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          en;
    logic          rdy;
    logic          exp_rd_en;
    logic          exp_valid;
    logic          exp_busy;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic rdy, input logic rd,
                              input logic v, input logic b, input logic cd,
                              input logic [DW-1:0] d);
    vec_t r;
    r.en = en; r.rdy = rdy; r.exp_rd_en = rd; r.exp_valid = v;
    r.exp_busy = b; r.chk_data = cd; r.exp_data = d;
    return r;
  endfunction

  task automatic run_vecs(input string tag, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      enable      = vecs[i].en;
      bus.m_ready = vecs[i].rdy;
      at_neg();
      chk({tag, "_rd_en"},   {31'd0, bus.fifo_rd_en}, {31'd0, vecs[i].exp_rd_en});
      chk({tag, "_m_valid"}, {31'd0, bus.m_valid},    {31'd0, vecs[i].exp_valid});
      chk({tag, "_busy"},    {31'd0, busy},           {31'd0, vecs[i].exp_busy});
      if (vecs[i].chk_data) chk({tag, "_m_data"}, bus.m_data, vecs[i].exp_data);
      next_cycle();
    end
  endtask

  initial begin
    // Streaming, 8 words, m_ready=1: cycles 0..10.
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h2));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h3));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h4));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h5));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h6));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 32'h7));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0));
    // Backpressure, 8 words, m_ready=0 for cycles 0..4: indices 11..24.
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 32'h1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 32'h1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 32'h1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h2));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h3));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h4));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h5));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'h6));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 32'h7));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0));

    // ---- reset state, with a word in the FIFO while reset is held ----
    rst_n       = 1'b0;
    enable      = 1'b1;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(32'hDEAD_0001);
    #1;
    chk("reset_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("reset_m_valid", {31'd0, bus.m_valid},    32'd0);
    chk("reset_m_data",  bus.m_data,              32'd0);
    chk("reset_busy",    {31'd0, busy},           32'd0);
`ifdef SYNC_FIFO_READER_STATS_EN
    chk("reset_beat_cnt", {28'd0, beat_cnt}, 32'd0);
`endif
    flush();
    rst_n = 1'b1;
    next_cycle();

    // ---- streaming ----
    for (int i = 1; i <= 8; i++) push(i);
    run_vecs("stream", 0, 10);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_no_rd_when_empty", rd_when_empty, 0);

    // ---- backpressure ----
    for (int i = 1; i <= 8; i++) push(i);
    run_vecs("bp", 11, 24);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_no_rd_when_empty", rd_when_empty, 0);

    // ---- empty guard: 20 cycles, FIFO empty, enable=1 ----
    enable      = 1'b1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      at_neg();
      chk("empty_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
      chk("empty_m_valid", {31'd0, bus.m_valid},    32'd0);
      next_cycle();
    end

    // ---- enable drop the cycle after a read issue ----
    push(32'hA1); push(32'hA2); push(32'hA3);
    enable = 1'b1;
    at_neg();
    chk("endrop_issue", {31'd0, bus.fifo_rd_en}, 32'd1);
    next_cycle();
    enable = 1'b0;
    at_neg();
    chk("endrop_rd_en_same_cycle", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("endrop_busy_inflight",    {31'd0, busy},           32'd1);
    next_cycle();
    at_neg();
    chk("endrop_m_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("endrop_m_data",  bus.m_data,           32'hA1);
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      at_neg();
      chk("endrop_no_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
      chk("endrop_busy_low", {31'd0, busy},           32'd0);
      next_cycle();
    end
    chk("endrop_left_in_fifo", exp_q.size(), 2);
    flush();
    enable = 1'b1;

    // ---- reset mid-stream ----
    for (int i = 1; i <= 8; i++) push(32'h10 + i);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", {31'd0, bus.m_valid},    32'd0);
    chk("midrst_m_data",  bus.m_data,              32'd0);
    chk("midrst_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("midrst_busy",    {31'd0, busy},           32'd0);
`ifdef SYNC_FIFO_READER_STATS_EN
    chk("midrst_beat_cnt", {28'd0, beat_cnt}, 32'd0);
`endif
    flush();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    at_neg();
    chk("midrst_after_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("midrst_after_busy",    {31'd0, busy},        32'd0);
    next_cycle();

`ifdef SYNC_FIFO_READER_STATS_EN
    // ---- saturating beat counter: 20 pops into a 4-bit counter ----
    for (int i = 0; i < 20; i++) push(32'h100 + i);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      at_neg();
      next_cycle();
    end
    // Cycles 0..7 deliver words on cycles 2..7: six pops so far.
    chk("stats_partial", {28'd0, beat_cnt}, 32'd6);
    for (int c = 0; c < 20; c++) begin
      at_neg();
      next_cycle();
    end
    chk("stats_saturated", {28'd0, beat_cnt}, 32'hF);
    chk("stats_drained",   exp_q.size(),      0);
`endif

    chk("final_no_rd_when_empty", rd_when_empty, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
